// File: rtl/pht_trainer.sv
// Gshare index generation plus an in-order FIFO of in-flight predictions.
// Retiring an entry writes the trained counter back to the PHT and repairs the GHR on a mispredict.
module pht_trainer #(
  parameter int INDEX_W = 10,
  parameter int DEPTH   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               predict_valid,
  input  logic [15:0]        predict_pc,
  output logic               predict_ready,
  output logic               predict_taken,
  output logic [INDEX_W-1:0] pht_index,
  input  logic [1:0]         pht_prediction,
  input  logic               resolve_valid,
  input  logic               resolve_taken,
  output logic               update,
  output logic [INDEX_W-1:0] updated_index,
  output logic [1:0]         updated_counter,
  output logic               mispredict,
  output logic               resolve_error
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [INDEX_W-1:0] index;
    logic [1:0]         ctr;
    logic [INDEX_W-1:0] ghr_snap;
  } entry_t;

  entry_t             fifo [DEPTH];
  logic [PTR_W-1:0]   rd_ptr, wr_ptr;
  logic [CNT_W-1:0]   count;
  logic [INDEX_W-1:0] ghr;

  entry_t     head;
  logic       do_push, do_res, mis_now;
  logic [1:0] new_ctr, push_ctr;

  assign pht_index     = predict_pc[INDEX_W:1] ^ ghr;
  assign predict_taken = pht_prediction[1];
  assign predict_ready = (count != CNT_W'(DEPTH));

  always_comb begin
    head     = fifo[rd_ptr];
    do_push  = predict_valid && predict_ready;
    do_res   = resolve_valid && (count != '0);
    new_ctr  = head.ctr;
    if (resolve_taken) begin
      if (head.ctr != 2'b11) new_ctr = head.ctr + 2'b01;
    end else begin
      if (head.ctr != 2'b00) new_ctr = head.ctr - 2'b01;
    end
    mis_now  = do_res && (head.ctr[1] != resolve_taken);
    // A push aliasing the retiring index must see the counter the PHT has not yet been written with.
    push_ctr = (do_res && (pht_index == head.index)) ? new_ctr : pht_prediction;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ghr             <= '0;
      rd_ptr          <= '0;
      wr_ptr          <= '0;
      count           <= '0;
      update          <= 1'b0;
      mispredict      <= 1'b0;
      updated_index   <= '0;
      updated_counter <= 2'b00;
      resolve_error   <= 1'b0;
      // NOTE: the entry storage is reset too, because forwarding rewrites entries in place every retire.
      for (int i = 0; i < DEPTH; i++) fifo[i] <= '0;
    end else begin
      update     <= do_res;
      mispredict <= mis_now;
      if (do_res) begin
        updated_index   <= head.index;
        updated_counter <= new_ctr;
      end
      if (resolve_valid && (count == '0)) resolve_error <= 1'b1;

      if (mis_now) begin
        // Recovery wins over any speculative shift and drops a same-cycle push.
        ghr    <= {head.ghr_snap[INDEX_W-2:0], resolve_taken};
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (do_res) begin
          for (int i = 0; i < DEPTH; i++)
            if (fifo[i].index == head.index) fifo[i].ctr <= new_ctr;
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        if (do_push) begin
          fifo[wr_ptr] <= '{index: pht_index, ctr: push_ctr, ghr_snap: ghr};
          ghr          <= {ghr[INDEX_W-2:0], push_ctr[1]};
          wr_ptr       <= wr_ptr + PTR_W'(1);
        end
        count <= count + CNT_W'(do_push) - CNT_W'(do_res);
      end
    end
  end

endmodule

// File: tb/tb_pht_trainer.sv
// Directed bench for pht_trainer; the GHR is observed through pht_index with predict_pc held at 0.
module tb_pht_trainer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       predict_valid = 1'b0;
  logic [15:0] predict_pc = '0;
  logic       predict_ready, predict_taken;
  logic [9:0] pht_index;
  logic [1:0] pht_prediction = 2'b00;
  logic       resolve_valid = 1'b0, resolve_taken = 1'b0;
  logic       update, mispredict, resolve_error;
  logic [9:0] updated_index;
  logic [1:0] updated_counter;

  int checks = 0;
  int failures = 0;

  pht_trainer #(.INDEX_W(10), .DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .predict_valid(predict_valid), .predict_pc(predict_pc), .predict_ready(predict_ready),
    .predict_taken(predict_taken), .pht_index(pht_index), .pht_prediction(pht_prediction),
    .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
    .update(update), .updated_index(updated_index), .updated_counter(updated_counter),
    .mispredict(mispredict), .resolve_error(resolve_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] pc, input logic [1:0] pred);
    predict_valid = 1'b1; predict_pc = pc; pht_prediction = pred;
    tick();
    predict_valid = 1'b0; predict_pc = '0;
  endtask

  task automatic resolve(input logic taken);
    resolve_valid = 1'b1; resolve_taken = taken;
    tick();
    resolve_valid = 1'b0;
  endtask

  task automatic ghr_is(input string tag, input logic [9:0] exp);
    predict_pc = '0;
    #1;
    chk(tag, 32'(pht_index), 32'(exp));
  endtask

  task automatic upd_is(input string tag, input logic [9:0] idx, input logic [1:0] ctr, input logic mis);
    chk({tag, "_update"}, 32'(update), 32'd1);
    chk({tag, "_index"}, 32'(updated_index), 32'(idx));
    chk({tag, "_counter"}, 32'(updated_counter), 32'(ctr));
    chk({tag, "_mispredict"}, 32'(mispredict), 32'(mis));
  endtask

  initial begin
    logic [9:0] drain_idx [4];
    drain_idx = '{10'h00D, 10'h01B, 10'h037, 10'h06F};

    #12 reset = 1'b0;
    tick();
    chk("rst_update", 32'(update), 32'd0);
    chk("rst_mispredict", 32'(mispredict), 32'd0);
    chk("rst_uidx", 32'(updated_index), 32'd0);
    chk("rst_uctr", 32'(updated_counter), 32'd0);
    chk("rst_error", 32'(resolve_error), 32'd0);
    chk("rst_ready", 32'(predict_ready), 32'd1);
    ghr_is("rst_ghr", 10'h000);

    // First prediction, mispredicted taken.
    predict_valid = 1'b1; predict_pc = 16'h0010; pht_prediction = 2'b01;
    #1;
    chk("p1_index", 32'(pht_index), 32'h008);
    chk("p1_taken", 32'(predict_taken), 32'd0);
    tick();
    predict_valid = 1'b0; predict_pc = '0;
    ghr_is("p1_ghr", 10'h000);
    resolve(1'b1);
    upd_is("r1", 10'h008, 2'b10, 1'b1);
    ghr_is("r1_ghr", 10'h001);
    tick();
    chk("r1_pulse", 32'(update), 32'd0);
    chk("r1_mis_pulse", 32'(mispredict), 32'd0);

    // Saturation at both ends.
    push(16'h0000, 2'b11);
    resolve(1'b1);
    upd_is("sat_hi", 10'h001, 2'b11, 1'b0);
    ghr_is("sat_hi_ghr", 10'h003);
    push(16'h0000, 2'b00);
    resolve(1'b0);
    upd_is("sat_lo", 10'h003, 2'b00, 1'b0);
    ghr_is("sat_lo_ghr", 10'h006);

    // Fill the FIFO, reject a fifth push, then free one slot.
    for (int i = 0; i < 4; i++) push(16'h0000, 2'b11);
    chk("full_ready", 32'(predict_ready), 32'd0);
    push(16'h0000, 2'b11);
    ghr_is("full_reject_ghr", 10'h06F);
    resolve_valid = 1'b1; resolve_taken = 1'b1;
    #1;
    chk("full_ready_same_cycle", 32'(predict_ready), 32'd0);
    tick();
    resolve_valid = 1'b0;
    upd_is("full_res", 10'h006, 2'b11, 1'b0);
    chk("full_ready_after", 32'(predict_ready), 32'd1);
    push(16'h0000, 2'b11);
    chk("count3_refill", 32'(predict_ready), 32'd0);
    resolve_valid = 1'b1; resolve_taken = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("drain_index", 32'(updated_index), 32'(drain_idx[i]));
      chk("drain_mis", 32'(mispredict), 32'd0);
    end
    resolve_valid = 1'b0;
    chk("drain_ready", 32'(predict_ready), 32'd1);
    ghr_is("drain_ghr", 10'h0DF);

    // Mispredict flush with a simultaneous push.
    for (int i = 0; i < 3; i++) push(16'h0000, 2'b10);
    resolve_valid = 1'b1; resolve_taken = 1'b0;
    predict_valid = 1'b1; predict_pc = 16'h0000; pht_prediction = 2'b10;
    tick();
    resolve_valid = 1'b0; predict_valid = 1'b0;
    upd_is("flush", 10'h0DF, 2'b01, 1'b1);
    ghr_is("flush_ghr", 10'h1BE);
    chk("flush_ready", 32'(predict_ready), 32'd1);

    // Resolve on an empty FIFO.
    resolve(1'b1);
    chk("empty_update", 32'(update), 32'd0);
    chk("empty_error", 32'(resolve_error), 32'd1);
    ghr_is("empty_ghr", 10'h1BE);

    // Forwarding to a queued entry at the same index.
    push(16'h03D6, 2'b10);
    push(16'h0650, 2'b10);
    resolve(1'b1);
    upd_is("fwd_a", 10'h055, 2'b11, 1'b0);
    resolve(1'b0);
    upd_is("fwd_b", 10'h055, 2'b10, 1'b1);
    ghr_is("fwd_b_ghr", 10'h2FA);

    // Forwarding to a push in the retire cycle.
    push(16'h055E, 2'b10);
    resolve_valid = 1'b1; resolve_taken = 1'b1;
    predict_valid = 1'b1; predict_pc = 16'h0340; pht_prediction = 2'b00;
    #1;
    chk("fwdp_index", 32'(pht_index), 32'h055);
    tick();
    resolve_valid = 1'b0; predict_valid = 1'b0;
    upd_is("fwdp_a", 10'h055, 2'b11, 1'b0);
    ghr_is("fwdp_ghr", 10'h3EB);
    resolve(1'b1);
    upd_is("fwdp_c", 10'h055, 2'b11, 1'b0);
    chk("error_sticky", 32'(resolve_error), 32'd1);

    // Asynchronous reset with one entry still outstanding.
    push(16'h0000, 2'b11);
    push(16'h0000, 2'b11);
    resolve(1'b1);
    upd_is("pre_reset", 10'h3EB, 2'b11, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("arst_update", 32'(update), 32'd0);
    chk("arst_uidx", 32'(updated_index), 32'd0);
    chk("arst_uctr", 32'(updated_counter), 32'd0);
    chk("arst_error", 32'(resolve_error), 32'd0);
    chk("arst_ready", 32'(predict_ready), 32'd1);
    ghr_is("arst_ghr", 10'h000);
    #1 reset = 1'b0;
    resolve(1'b1);
    chk("post_reset_update", 32'(update), 32'd0);
    chk("post_reset_error", 32'(resolve_error), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
